// File: rtl/fetch_seq_if.sv
// rtl/fetch_seq_if.sv - fetch sequencer memory, redirect and decode handshake bundle
interface fetch_seq_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_instr;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );
endinterface

// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - instruction-fetch PC sequencer over a 1-cycle synchronous-read memory
module fetch_seq #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_seq_if.master       bus,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] RST_PC = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] resp_pc;
  logic              resp_valid;

  logic              is_halt;
  logic              out_valid_c;
  logic              accept;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] addr_c;

  // resp_pc always names the word the memory is presenting on imem_instr.
  always_comb begin
    is_halt     = (state == RUN) && resp_valid && (bus.imem_instr == 32'd0);
    out_valid_c = resp_valid && (state == RUN) && !bus.redirect_valid && !is_halt;
    accept      = out_valid_c && bus.out_ready;
    pc_inc      = resp_pc + PC_ONE;
    addr_c      = resp_pc;
    if (bus.redirect_valid) begin
      addr_c = bus.redirect_pc;
    end else begin
      unique case (state)
        BOOT:    addr_c = RST_PC;
        RUN:     addr_c = (!is_halt && accept) ? pc_inc : resp_pc;
        HALT:    addr_c = resp_pc;
        default: addr_c = RST_PC;
      endcase
    end
  end

  assign bus.imem_addr = addr_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_instr = out_valid_c ? bus.imem_instr : 32'd0;
  assign bus.out_pc    = resp_pc;
  assign halted        = (state == HALT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= BOOT;
      resp_valid  <= 1'b0;
      resp_pc     <= RST_PC;
      fetch_count <= 32'd0;
    end else if (bus.redirect_valid) begin
      // Redirect wins from every state; the word on imem_instr is wrong-path.
      state      <= RUN;
      resp_valid <= 1'b1;
      resp_pc    <= bus.redirect_pc;
    end else begin
      unique case (state)
        BOOT: begin
          state      <= RUN;
          resp_valid <= 1'b1;
          resp_pc    <= RST_PC;
        end
        RUN: begin
          if (is_halt) begin
            state <= HALT;
          end else if (accept) begin
            resp_pc     <= pc_inc;
            fetch_count <= fetch_count + 32'd1;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state      <= BOOT;
          resp_valid <= 1'b0;
          resp_pc    <= RST_PC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// tb/tb_fetch_seq.sv - scoreboard bench for fetch_seq against a modelled instr_mem
module tb_fetch_seq;

  logic        clk;
  logic        rst_n;
  logic        halted;
  logic [31:0] fetch_count;

  fetch_seq_if #(.ADDR_W(32)) bus ();

  fetch_seq #(.ADDR_W(32), .RESET_PC(32'd0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  int compared   = 0;
  int mismatched = 0;
  bit done       = 0;
  logic [63:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd0:   mem_word = 32'h00100293;
      32'd1:   mem_word = 32'h00500313;
      32'd2:   mem_word = 32'hFFF00393;
      32'd18:  mem_word = 32'hFE006EE3;
      32'd22:  mem_word = 32'h00000000;
      default: mem_word = (a < 32'd32) ? (32'h1000_0000 | a) : (32'hA500_0000 ^ a);
    endcase
  endfunction

  always @(posedge clk) bus.imem_instr <= mem_word(bus.imem_addr);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  task automatic push_range(input logic [31:0] lo, input logic [31:0] hi);
    for (logic [32:0] p = {1'b0, lo}; p <= {1'b0, hi}; p++) push(p[31:0]);
  endtask

  // Returns at posedge+1 of the cycle presenting the target pc.
  task automatic wait_pc(input logic [31:0] pc, input string name);
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (bus.out_valid && bus.out_pc == pc) return;
    end
    compared++;
    mismatched++;
    $display("FAIL %s: timeout waiting for out_pc %h", name, pc);
  endtask

  task automatic wait_halt(input string name);
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (halted) return;
    end
    compared++;
    mismatched++;
    $display("FAIL %s: timeout waiting for halted", name);
  endtask

  // Monitor: every handshake must match the head of the expected queue.
  always @(negedge clk) begin
    if (!done && rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_delivery: got pc %h instr %h expected none", bus.out_pc, bus.out_instr);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("deliver_pc", bus.out_pc, e[63:32]);
          check("deliver_instr", bus.out_instr, e[31:0]);
        end
      end else if (!bus.out_valid) begin
        check("idle_instr_zero", bus.out_instr, 32'd0);
      end
    end
  end

  initial begin
    rst_n              = 1'b0;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_out_pc", bus.out_pc, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_imem_addr", bus.imem_addr, 32'd0);

    // Sequential run with a 3-cycle stall at pc 1, then halt at word 22.
    push_range(32'd0, 32'd21);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_pc(32'd1, "wait_pc1");
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stall_pc", bus.out_pc, 32'd1);
      check("stall_instr", bus.out_instr, 32'h00500313);
      check("stall_imem_addr", bus.imem_addr, 32'd1);
      check("stall_count", fetch_count, 32'd1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    wait_halt("wait_halt1");
    @(negedge clk);
    check("halt_valid", {31'd0, bus.out_valid}, 32'd0);
    check("halt_count", fetch_count, 32'd22);
    check("halt_imem_addr", bus.imem_addr, 32'd22);

    // Halt exit via redirect to 2.
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd2;
    @(negedge clk);
    check("hexit_valid", {31'd0, bus.out_valid}, 32'd0);
    check("hexit_imem_addr", bus.imem_addr, 32'd2);
    check("hexit_halted_still", {31'd0, halted}, 32'd1);
    push_range(32'd2, 32'd4);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("hexit_halted_drop", {31'd0, halted}, 32'd0);
    check("hexit_pc", bus.out_pc, 32'd2);

    // Redirect to 18 while pc 5 is on offer.
    wait_pc(32'd5, "wait_pc5");
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd18;
    @(negedge clk);
    check("redir_valid", {31'd0, bus.out_valid}, 32'd0);
    check("redir_imem_addr", bus.imem_addr, 32'd18);
    check("redir_count", fetch_count, 32'd25);
    push_range(32'd18, 32'd21);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    wait_halt("wait_halt2");
    @(negedge clk);
    check("halt2_count", fetch_count, 32'd29);

    // Redirect from halt to 7, then redirect with out_ready low at pc 8.
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd7;
    push(32'd7);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    wait_pc(32'd8, "wait_pc8");
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd12;
    @(negedge clk);
    check("redir_nr_valid", {31'd0, bus.out_valid}, 32'd0);
    check("redir_nr_imem_addr", bus.imem_addr, 32'd12);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_nr_pc", bus.out_pc, 32'd12);
    check("redir_nr_instr", bus.out_instr, 32'h1000000C);
    check("redir_nr_count", fetch_count, 32'd30);
    push_range(32'd12, 32'd13);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;

    // PC wrap: redirect to the top word, then accept rolls to 0.
    wait_pc(32'd14, "wait_pc14");
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFF;
    push(32'hFFFF_FFFF);
    push_range(32'd0, 32'd9);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;

    // Reset while pc 10 is on offer.
    wait_pc(32'd10, "wait_pc10");
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mrst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mrst_halted", {31'd0, halted}, 32'd0);
    check("mrst_count", fetch_count, 32'd0);
    check("mrst_imem_addr", bus.imem_addr, 32'd0);
    push_range(32'd0, 32'd2);
    @(posedge clk); #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    wait_pc(32'd3, "wait_pc3");
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("refetch_count", fetch_count, 32'd3);
    check("queue_drained", exp_q.size(), 32'd0);
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction-fetch sequencer that owns the address port of the word-addressed, synchronous-read instruction memory `instr_mem`. It generates the fetch PC, compensates for the memory's one-cycle registered read, holds fetch under back-pressure, and applies branch/jump redirects from execute. Fetched instructions go to decode over a valid/ready handshake. An all-zero instruction word halts fetch.

## Interface
- `RESET_PC`, 0: word address fetched first after reset.
- `ADDR_W`, 32: PC / memory address width; PC arithmetic wraps modulo 2^ADDR_W.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `imem_addr`  out  ADDR_W: word address to `instr_mem.addr`; combinational from state and inputs.
- `imem_instr`  in  32: `instr_mem.instr`; holds the word at the address sampled on the previous edge.
- `redirect_valid`  in  1: execute requests a PC change this cycle.
- `redirect_pc`  in  ADDR_W: redirect target word address.
- `out_valid`  out  1: instruction available to decode.
- `out_ready`  in  1: decode accepts when `out_valid & out_ready`.
- `out_instr`  out  32: `imem_instr` when `out_valid`, else 0.
- `out_pc`  out  ADDR_W: word address of `out_instr` (`resp_pc`).
- `halted`  out  1: fetch stopped on a zero instruction word.
- `fetch_count`  out  32: count of accepted instructions; wraps.

## Operation
- State: `state` ∈ {BOOT, RUN, HALT}; `resp_pc` (address whose data is on `imem_instr`); `resp_valid`; `fetch_count`.
- Reset (`rst_n` low at an edge): state=BOOT, `resp_valid`=0, `resp_pc`=RESET_PC, `fetch_count`=0.
- Reset output values: `out_valid`=0, `out_instr`=0, `out_pc`=RESET_PC, `halted`=0, `fetch_count`=0, `imem_addr`=RESET_PC.
- BOOT:
  - `imem_addr`=RESET_PC, `out_valid`=0.
  - Next edge: RUN, `resp_valid`=1, `resp_pc`=RESET_PC.
  - A redirect in BOOT acts as in RUN.
- RUN, `is_halt` = `resp_valid & (imem_instr == 0)`. At each edge, first match wins:
  1. `redirect_valid`: `imem_addr`=`redirect_pc`, `resp_pc`←`redirect_pc`, `resp_valid`←1. `out_valid` is forced 0 this cycle; the wrong-path word is squashed.
  2. `is_halt`: `out_valid`=0, `imem_addr`=`resp_pc`, state←HALT. The zero word is never delivered.
  3. Accept (`out_valid & out_ready`): `imem_addr`=`resp_pc+1`, `resp_pc`←`resp_pc+1`, `fetch_count`←+1.
  4. Stall: `imem_addr`=`resp_pc`, so the memory re-reads the same word and `out_instr` and `out_pc` stay stable.
- HALT:
  - `halted`=1, `out_valid`=0, `imem_addr`=`resp_pc`.
  - `redirect_valid` → RUN with the same action as RUN item 1. `halted` drops the following cycle.
- `out_valid` = `resp_valid & (state==RUN) & ~redirect_valid & ~is_halt`.
- The count increments only on a handshake. Redirect and halt cycles never count.

## Timing
- Memory latency is 1 cycle. Sequential fetch sustains 1 instruction/cycle with `out_ready`=1.
- First `out_valid` appears in the cycle after the first edge with `rst_n`=1.
- Redirect penalty is 0 bubbles beyond the squashed cycle. Target is valid in the cycle after `redirect_valid`.
- Combinational paths: `redirect_valid`, `redirect_pc`, `out_ready`, `imem_instr` → `imem_addr`/`out_valid`. Decode must not make `out_ready` depend on `redirect_valid`.
- Under stall, `out_instr`/`out_pc` are held for any number of cycles. `out_valid` never drops without a handshake, except on redirect, halt detection, or reset.
- PC wrap: `resp_pc` = 2^ADDR_W−1 then accept → 0.
- Reset mid-operation discards any in-flight word. No output glitches past the reset edge.

## Test plan
- Default memory contents, `out_ready`=1 after reset:
  - Cycle 1: `out_pc`=0, `out_instr`=0x00100293.
  - Next: `out_pc`=1, `out_instr`=0x00500313.
  - Continues to `out_pc`=21. At `resp_pc`=22 (zero word): `halted`=1, `out_valid`=0, `fetch_count`=22.
- Stall: `out_ready`=0 for 3 cycles at `out_pc`=1 → `out_pc`=1, `out_instr`=0x00500313, `imem_addr`=1 held, `fetch_count` unchanged. Release → `out_pc`=2, `out_instr`=0xFFF00393.
- Redirect: `redirect_pc`=18 while `out_pc`=5 → `out_valid`=0 that cycle, no count. Next cycle `out_pc`=18, `out_instr`=0xFE006EE3.
- Redirect with `out_ready`=0 in the same cycle → redirect wins; next `out_pc`=`redirect_pc`.
- Halt exit: in HALT, `redirect_pc`=2 → next cycle `halted`=0, `out_pc`=2, `out_instr`=0xFFF00393.
- Reset at `out_pc`=10 → next cycle `out_valid`=0, `halted`=0, `fetch_count`=0, `imem_addr`=RESET_PC. Refetch restarts at 0.
